// File: rtl/seq_serializer.sv
// ---------------------------------------------------------------------------
// seq_serializer
//
// Parallel-to-serial front end that feeds the sequence detector's seqIn.
// It accepts WIDTH-bit words over a valid/ready handshake and shifts each
// word out one bit per clock. A one-word holding register lets consecutive
// words stream back to back with no idle bubble between them.
//
// Parameters:
//   WIDTH      bits per word (2..64)
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//   IDLE_LEVEL level driven on seqOut while nothing is being shifted
//
// Ports:
//   clk       clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   inData    word to serialize, sampled only on transfer
//   inValid   inData is valid
//   inReady   block can accept a word this cycle (= holding register empty)
//   seqOut    serial data bit
//   seqValid  seqOut carries a real data bit
//   wordLast  seqOut is the final bit of the current word
//   busy      shifter active or holding register occupied
// ---------------------------------------------------------------------------
module seq_serializer #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] inData,
   input  logic             inValid,
   output logic             inReady,
   output logic             seqOut,
   output logic             seqValid,
   output logic             wordLast,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_reg;
   logic [WIDTH-1:0]   shift_reg;
   logic [WIDTH-1:0]   hold_reg;
   logic               hold_full_reg;
   logic [CNT_W-1:0]   bit_cnt_reg;

   // Words are reordered once on capture so the shifter always moves left and
   // the transmitted bit is always shift_reg[WIDTH-1], whatever the bit order.
   logic [WIDTH-1:0]   in_ordered;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_order
         if (MSB_FIRST) begin : g_msb
            assign in_ordered[gi] = inData[gi];
         end else begin : g_lsb
            assign in_ordered[gi] = inData[WIDTH-1-gi];
         end
      end
   endgenerate

   logic transfer;
   logic at_last;

   assign transfer = inValid && !hold_full_reg;
   assign at_last  = (bit_cnt_reg == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         bit_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               // Holding register is always empty here, so the word goes
               // straight into the shifter.
               if (transfer) begin
                  shift_reg   <= in_ordered;
                  bit_cnt_reg <= '0;
                  state_reg   <= SHIFT;
               end
            end

            SHIFT: begin
               if (at_last) begin
                  if (hold_full_reg) begin
                     // inReady was low this cycle, so no transfer competes.
                     shift_reg     <= hold_reg;
                     hold_full_reg <= 1'b0;
                     bit_cnt_reg   <= '0;
                  end else if (transfer) begin
                     shift_reg   <= in_ordered;
                     bit_cnt_reg <= '0;
                  end else begin
                     shift_reg   <= '0;
                     bit_cnt_reg <= '0;
                     state_reg   <= IDLE;
                  end
               end else begin
                  shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
                  bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                  if (transfer) begin
                     hold_reg      <= in_ordered;
                     hold_full_reg <= 1'b1;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // All outputs are decoded from registered state only.
   assign inReady  = !hold_full_reg;
   assign seqValid = (state_reg == SHIFT);
   assign seqOut   = (state_reg == SHIFT) ? shift_reg[WIDTH-1] : IDLE_LEVEL;
   assign wordLast = (state_reg == SHIFT) && at_last;
   assign busy     = (state_reg == SHIFT) || hold_full_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_serializer
//
// Two instances: one MSB-first, one LSB-first (both WIDTH=8, IDLE_LEVEL=0).
// Drivers push the expected serial bits of every accepted word into a queue;
// one monitor per instance pops a bit on every seqValid cycle and compares
// seqOut/wordLast, and flags a gap whenever bits are pending but seqValid=0.
// ---------------------------------------------------------------------------
module tb_seq_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] in_data_m  = '0;
   logic       in_valid_m = 1'b0;
   logic       in_ready_m, seq_out_m, seq_valid_m, word_last_m, busy_m;

   logic [7:0] in_data_l  = '0;
   logic       in_valid_l = 1'b0;
   logic       in_ready_l, seq_out_l, seq_valid_l, word_last_l, busy_l;

   int checks   = 0;
   int failures = 0;

   // Expected entries: {bit, last}
   logic [1:0] q_m[$];
   logic [1:0] q_l[$];

   always #5 clk = ~clk;

   seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
      .clk(clk), .rst(rst),
      .inData(in_data_m), .inValid(in_valid_m), .inReady(in_ready_m),
      .seqOut(seq_out_m), .seqValid(seq_valid_m), .wordLast(word_last_m),
      .busy(busy_m)
   );

   seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
      .clk(clk), .rst(rst),
      .inData(in_data_l), .inValid(in_valid_l), .inReady(in_ready_l),
      .seqOut(seq_out_l), .seqValid(seq_valid_l), .wordLast(word_last_l),
      .busy(busy_l)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (!rst) begin
         logic [1:0] e;
         if (seq_valid_m) begin
            checks++;
            if (q_m.size() == 0) begin
               failures++;
               $display("FAIL msb_extra: got bit %b with nothing expected at %0t", seq_out_m, $time);
            end else begin
               e = q_m.pop_front();
               if ({seq_out_m, word_last_m} !== e) begin
                  failures++;
                  $display("FAIL msb_bit: got bit/last %b%b expected %b%b at %0t",
                           seq_out_m, word_last_m, e[1], e[0], $time);
               end
            end
         end else begin
            checks++;
            if (q_m.size() != 0 || seq_out_m !== 1'b0 || word_last_m !== 1'b0) begin
               failures++;
               $display("FAIL msb_idle: seqOut %b wordLast %b pending %0d expected 0 0 0 at %0t",
                        seq_out_m, word_last_m, q_m.size(), $time);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         logic [1:0] e;
         if (seq_valid_l) begin
            checks++;
            if (q_l.size() == 0) begin
               failures++;
               $display("FAIL lsb_extra: got bit %b with nothing expected at %0t", seq_out_l, $time);
            end else begin
               e = q_l.pop_front();
               if ({seq_out_l, word_last_l} !== e) begin
                  failures++;
                  $display("FAIL lsb_bit: got bit/last %b%b expected %b%b at %0t",
                           seq_out_l, word_last_l, e[1], e[0], $time);
               end
            end
         end else begin
            checks++;
            if (q_l.size() != 0 || seq_out_l !== 1'b0 || word_last_l !== 1'b0) begin
               failures++;
               $display("FAIL lsb_idle: seqOut %b wordLast %b pending %0d expected 0 0 0 at %0t",
                        seq_out_l, word_last_l, q_l.size(), $time);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // pat lists the serial bits in time order, first bit in pat[7].
   task automatic push_pattern(input bit lsb, input logic [7:0] pat);
      for (int i = 7; i >= 0; i--) begin
         if (lsb) q_l.push_back({pat[i], (i == 0)});
         else     q_m.push_back({pat[i], (i == 0)});
      end
   endtask

   // Called at posedge+#1. With use_data=1 the expected pattern is the word
   // actually captured (MSB-first instance: time order equals bit order).
   // scramble=1 changes inData every cycle the word is stalled.
   task automatic send(input bit lsb, input logic [7:0] w, input logic [7:0] pat,
                       input bit use_data, input bit scramble);
      logic rdy;
      bit   done = 0;
      if (lsb) begin in_data_l = w; in_valid_l = 1'b1; end
      else     begin in_data_m = w; in_valid_m = 1'b1; end
      for (int c = 0; c < 100 && !done; c++) begin
         rdy = lsb ? in_ready_l : in_ready_m;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1;
            push_pattern(lsb, use_data ? (lsb ? in_data_l : in_data_m) : pat);
            $display("accept %s word %h at %0t", lsb ? "lsb" : "msb",
                     lsb ? in_data_l : in_data_m, $time);
            if (lsb) in_valid_l = 1'b0; else in_valid_m = 1'b0;
         end else if (scramble) begin
            if (lsb) in_data_l = 8'($urandom); else in_data_m = 8'($urandom);
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
         in_valid_l = 1'b0;
         in_valid_m = 1'b0;
      end
   endtask

   task automatic drain;
      bit done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (q_m.size() == 0 && q_l.size() == 0 && !busy_m && !busy_l) done = 1;
         else begin @(posedge clk); #1; end
      end
      check("drain", {7'b0, done}, 8'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset: {seqValid, seqOut, inReady, busy} = 0010
      for (int i = 0; i < 20; i++) begin
         check("idle_msb", {4'b0, seq_valid_m, seq_out_m, in_ready_m, busy_m}, 8'b0000_0010);
         check("idle_lsb", {4'b0, seq_valid_l, seq_out_l, in_ready_l, busy_l}, 8'b0000_0010);
         @(posedge clk);
         #1;
      end

      // Single word 0x93, MSB first
      send(0, 8'h93, 8'b1001_0011, 0, 0);
      drain();

      // Back-to-back words with valid held high
      send(0, 8'hA5, 8'b1010_0101, 0, 0);
      check("ready_after_first", {7'b0, in_ready_m}, 8'd1);
      send(0, 8'h3C, 8'b0011_1100, 0, 0);
      check("ready_after_hold", {6'b0, in_ready_m, busy_m}, 8'b01);
      send(0, 8'hFF, 8'b1111_1111, 0, 0);
      check("ready_after_third", {7'b0, in_ready_m}, 8'd0);
      drain();

      // LSB first
      send(1, 8'h01, 8'b1000_0000, 0, 0);
      drain();
      send(1, 8'h93, 8'b1100_1001, 0, 0);
      send(1, 8'h5A, 8'b0101_1010, 0, 0);
      drain();

      // Reset mid-word with a word in hold
      send(0, 8'h93, 8'b1001_0011, 0, 0);
      send(0, 8'hAA, 8'b1010_1010, 0, 0);
      check("hold_full", {7'b0, in_ready_m}, 8'd0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q_m.delete();
      q_l.delete();
      check("post_reset", {5'b0, seq_valid_m, busy_m, in_ready_m}, 8'b001);
      send(0, 8'h0F, 8'b0000_1111, 0, 0);
      drain();

      // Random traffic with stalls and changing data while not ready
      for (int n = 0; n < 1000; n++) begin
         int gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
         send(0, 8'($urandom), 8'h00, 1, 1);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
